// File: rtl/dfe_out_buffer.sv
// Output stage after the CIC + compensation FIR: Q1.15 gain with round/saturate,
// then a show-ahead FIFO drained over valid/ready with level/overflow/saturation status.
module dfe_out_buffer #(
  parameter int W     = 16,
  parameter int FRAC  = 15,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_enable,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_sample,
  input  logic [W-1:0]               gain,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_sample,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic                       sat_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [2*W:0] HALF = (2*W+1)'(1) << (FRAC - 1);
  localparam logic signed [2*W:0] MAXV = (2*W+1)'((1 << (W - 1)) - 1);
  localparam logic signed [2*W:0] MINV = -MAXV - (2*W+1)'(1);

  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   rnd_sum;
  logic signed [2*W:0]   scaled;
  logic [W-1:0]          sat_val;
  logic                  sat_flag;

  logic                  s1_valid_reg;
  logic [W-1:0]          s1_data_reg;
  logic                  s1_sat_reg;
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic [W-1:0]          last_reg;
  logic                  overflow_reg;
  logic                  sat_reg;
  logic [W-1:0]          mem [DEPTH];

  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  ovf_event;

  assign prod    = $signed(in_sample) * $signed(gain);
  assign rnd_sum = $signed({prod[2*W-1], prod}) + HALF;
  assign scaled  = rnd_sum >>> FRAC;

  always_comb begin
    sat_flag = 1'b0;
    sat_val  = scaled[W-1:0];
    if (scaled > MAXV) begin
      sat_flag = 1'b1;
      sat_val  = MAXV[W-1:0];
    end else if (scaled < MINV) begin
      sat_flag = 1'b1;
      sat_val  = MINV[W-1:0];
    end
  end

  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && clk_enable && !flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en     = s1_valid_reg && clk_enable && !flush && (!full || pop);
  assign ovf_event = s1_valid_reg && clk_enable && !flush && full && !pop;

  // Empty FIFO shows the last popped value rather than stale memory.
  assign out_sample = out_valid ? mem[rd_ptr_reg[AW-1:0]] : last_reg;
  assign overflow   = overflow_reg;
  assign sat_pulse  = sat_reg && clk_enable;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= s1_data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_sat_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      last_reg     <= '0;
      overflow_reg <= 1'b0;
      sat_reg      <= 1'b0;
    end else if (clk_enable) begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        last_reg     <= '0;
        sat_reg      <= 1'b0;
        if (clear_ovf) overflow_reg <= 1'b0;
      end else begin
        s1_valid_reg <= in_valid;
        s1_data_reg  <= sat_val;
        s1_sat_reg   <= sat_flag;
        sat_reg      <= s1_valid_reg && s1_sat_reg;
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          last_reg   <= mem[rd_ptr_reg[AW-1:0]];
        end
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (ovf_event)      overflow_reg <= 1'b1;
        else if (clear_ovf) overflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dfe_out_buffer.sv
// Randomized and directed bench for dfe_out_buffer; a queue-based reference model
// tracks FIFO contents and a negedge monitor compares every cycle.
module tb_dfe_out_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_enable = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_sample = '0;
  logic [W-1:0]  gain = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_sample;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clear_ovf = 1'b0;
  logic          sat_pulse;

  int total = 0;
  int bad   = 0;
  int sat_seen = 0;

  // reference model state
  logic [W-1:0]  fq[$];
  bit            st_v = 0;
  logic [W-1:0]  st_val = '0;
  bit            st_sat = 0;
  logic [W-1:0]  last_m = '0;
  bit            ovf_m = 0;
  bit            sat_m = 0;

  dfe_out_buffer #(.W(W), .FRAC(15), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .flush(flush),
    .in_valid(in_valid), .in_sample(in_sample), .gain(gain), .out_ready(out_ready),
    .out_valid(out_valid), .out_sample(out_sample), .level(level),
    .overflow(overflow), .clear_ovf(clear_ovf), .sat_pulse(sat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_scale(input logic [W-1:0] x, input logic [W-1:0] g,
                                    output logic [W-1:0] y, output bit s);
    longint p, r;
    p = longint'($signed(x)) * longint'($signed(g));
    r = (p + 64'sd16384) >>> 15;
    s = 0;
    if (r > 32767) begin r = 32767; s = 1; end
    else if (r < -32768) begin r = -32768; s = 1; end
    y = r[W-1:0];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor/scoreboard: compare at negedge, then advance the model with the
  // inputs the DUT will sample on the next rising edge.
  initial begin
    logic [W-1:0] exp_s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fq.delete(); st_v = 0; last_m = '0; ovf_m = 0; sat_m = 0;
      end
      exp_s = (fq.size() != 0) ? fq[0] : last_m;
      chk("out_valid", out_valid, (fq.size() != 0));
      chk("level", level, fq.size());
      chk("out_sample", out_sample, exp_s);
      chk("overflow", overflow, ovf_m);
      chk("sat_pulse", sat_pulse, clk_enable ? sat_m : 1'b0);
      if (sat_pulse) sat_seen++;
      if (rst_n && clk_enable) begin
        if (flush) begin
          fq.delete(); st_v = 0; last_m = '0; sat_m = 0;
          if (clear_ovf) ovf_m = 0;
        end else begin
          bit ovf_ev;
          ovf_ev = 0;
          if (fq.size() != 0 && out_ready) begin
            last_m = fq.pop_front();
            $display("pop 0x%04h level_after=%0d", last_m, fq.size());
          end
          sat_m = st_v && st_sat;
          if (st_v) begin
            if (fq.size() < DEPTH) fq.push_back(st_val);
            else ovf_ev = 1;
          end
          if (ovf_ev) ovf_m = 1;
          else if (clear_ovf) ovf_m = 0;
          st_v = in_valid;
          ref_scale(in_sample, gain, st_val, st_sat);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] sc_in  [4];
    logic [W-1:0] sc_exp [4];
    logic [W-1:0] held;
    logic [LW-1:0] lv;
    int prev, sat0;
    sc_in  = '{16'h4000, 16'h0001, 16'hFFFF, 16'h7FFF};
    sc_exp = '{16'h2000, 16'h0001, 16'h0000, 16'h4000};

    // reset
    step(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_sample", out_sample, 0);
    rst_n = 1'b1; clk_enable = 1'b1;
    step(1);

    // scaling and rounding
    gain = 16'h4000; out_ready = 0; sat0 = sat_seen;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sample = sc_in[i];
      step(1);
    end
    in_valid = 0;
    step(2);
    chk("scale_level", level, 4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("scale_value", out_sample, sc_exp[i]);
      step(1);
    end
    chk("scale_no_sat", sat_seen - sat0, 0);

    // saturation
    sat0 = sat_seen; gain = 16'h8000;
    in_valid = 1; in_sample = 16'h8000; step(1);
    in_sample = 16'h7FFF; step(1);
    in_valid = 0; step(4);
    chk("sat_pulses", sat_seen - sat0, 1);

    // latency
    in_valid = 1; in_sample = 16'h1234; gain = 16'h7FFF; step(1);
    in_valid = 0;
    chk("lat_k", out_valid, 0);
    step(1);
    chk("lat_k1_valid", out_valid, 1);
    chk("lat_k1_level", level, 1);
    step(1);
    chk("lat_k2_valid", out_valid, 0);
    chk("lat_k2_level", level, 0);

    // overflow
    out_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1; in_sample = 16'(i); step(1);
    end
    in_valid = 0; step(2);
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain", out_sample, i);
      step(1);
    end
    out_ready = 0; clear_ovf = 1; step(1);
    clear_ovf = 0;
    chk("ovf_cleared", overflow, 0);

    // full with simultaneous read and write
    for (int i = 11; i <= 19; i++) begin
      in_valid = 1; in_sample = 16'(i); step(1);
    end
    out_ready = 1; prev = out_sample;
    for (int i = 0; i < 20; i++) begin
      in_sample = 16'(20 + i); step(1);
      chk("fullrw_level", level, 8);
      chk("fullrw_ovf", overflow, 0);
      chk("fullrw_order", (int'(out_sample) > prev), 1);
      prev = out_sample;
    end
    in_valid = 0; step(12);

    // freeze
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sample = 16'(100 + i); step(1);
    end
    clk_enable = 0; out_ready = 1; lv = level; held = out_sample;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("freeze_level", level, lv);
      chk("freeze_sample", out_sample, held);
    end
    clk_enable = 1; in_valid = 0; step(6);

    // flush with level 5
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_sample = 16'(200 + i); step(1);
    end
    in_valid = 0; step(2);
    chk("flush_pre_level", level, 5);
    flush = 1; in_valid = 1; in_sample = 16'd77; step(1);
    flush = 0; in_valid = 0;
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_sample", out_sample, 0);
    step(2);
    chk("flush_discard", level, 0);

    // reset mid-burst with level 3
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sample = 16'(300 + i); step(1);
    end
    in_valid = 0; step(2);
    chk("rst_pre_level", level, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_sample", out_sample, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_sat", sat_pulse, 0);
    step(2);
    rst_n = 1; step(2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0: in_sample = 16'h8000;
        1: in_sample = 16'h7FFF;
        default: in_sample = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: gain = 16'h8000;
        1: gain = 16'h7FFF;
        2: gain = 16'h4000;
        default: gain = 16'($urandom);
      endcase
      out_ready  = ($urandom_range(0, 99) < 45);
      clk_enable = ($urandom_range(0, 99) < 90);
      flush      = ($urandom_range(0, 59) == 0);
      clear_ovf  = ($urandom_range(0, 99) < 5);
      step(1);
    end
    in_valid = 0; flush = 0; clear_ovf = 0; clk_enable = 1; out_ready = 1;
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
